hnf_rxchan_lcrd: RTL and testbench
==================================

# hnf_rxchan_lcrd

Generic, parametrised CHI link-layer receive channel for the HN-F. It replaces the fixed-size, single-flit-type receive blocks. It manages L-credits with a real outstanding-credit counter rather than a full/not-full level, gates reception with registered FLITPEND, and buffers flits in a POS queue. The queue drains through a valid/ready interface. One instance sits behind each of the HN-F RXREQ, RXRSP and RXDAT channels.

## Interface
- `WIDTH`, default 64: flit width in bits (`$bits` of the channel flit type).
- `DEPTH`, default 8: POS queue entries; at least 2.
- `MAX_LCRD`, default 8: maximum L-credits outstanding at the transmitter; at least 1, at most min(DEPTH, 15).
- `clock`, input, 1: single clock; all state updates on rising edge.
- `reset`, input, 1: synchronous, active-high.
- `RXFLITPEND`, input, 1: flit-pending, one cycle ahead of RXFLITV.
- `RXFLITV`, input, 1: flit valid.
- `RXFLIT`, input, WIDTH: flit payload.
- `RXLCRDV`, output, 1: L-credit grant, one credit per high cycle.
- `out_flit`, output, WIDTH: head-of-queue flit.
- `out_valid`, output, 1: head entry valid.
- `out_ready`, input, 1: consumer accepts head.
- `lcrd_outstanding`, output, 4: credits granted and not yet consumed.
- `occupancy`, output, $clog2(DEPTH+1): queued entries.
- `err_no_credit`, output, 1: sticky flag; a flit arrived with zero credits outstanding.
- `err_pend_miss`, output, 1: sticky flag; RXFLITV arrived without RXFLITPEND in the previous cycle.

## Operation
- `pend_q` <= RXFLITPEND, registered every cycle.
- Receive event `rx = RXFLITV`. The `pend_q` value only feeds `err_pend_miss`; the flit is still accepted.
- Credit accounting:
  - `rx` with `lcrd_outstanding > 0` pushes RXFLIT and decrements the counter.
  - `rx` with `lcrd_outstanding == 0` drops the flit and sets `err_no_credit`.
- Credit issue: at each edge, set RXLCRDV <= 1 and increment `lcrd_outstanding` when both conditions hold, evaluated on pre-edge values with the same-cycle consume applied:
  - `lcrd_outstanding < MAX_LCRD`
  - `occupancy + lcrd_outstanding < DEPTH`
- Otherwise RXLCRDV <= 0.
- The invariant `occupancy + lcrd_outstanding <= DEPTH` guarantees a push never hits a full queue.
- Simultaneous consume and issue: the counter is unchanged, and RXLCRDV is high next cycle.
- Pop on `out_valid & out_ready`.
- Push and pop in the same cycle: occupancy is unchanged. Freed entries become creditable on the following edge.
- Error flags are sticky and cleared only by reset.

## Timing
- Reset values: RXLCRDV=0, out_valid=0, lcrd_outstanding=0, occupancy=0, both error flags 0, pend_q=0.
- Reset mid-operation: queued flits and outstanding credits are discarded with no drain. The link partner is reset with the same `reset`.
- After reset deasserts, RXLCRDV goes high starting in the first cycle, one credit per cycle. It stays high for MAX_LCRD consecutive cycles, then low.
- Flit latency without bypass: a flit sampled at edge N appears on `out_valid`/`out_flit` after edge N.
- `out_flit` is stable while `out_valid & ~out_ready`.
- Queue order is FIFO with pointer wrap-around at DEPTH.

## Configuration
- `HNF_RXCHAN_BYPASS_EN` defined:
  - When the queue is empty and `rx` is accepted, `out_valid`/`out_flit` are driven combinationally from RXFLIT in the same cycle.
  - If `out_ready` is also high, the flit is not written and occupancy stays 0. The credit is still consumed, and is re-issued under the normal rule.
- Not defined: the registered path only, with one-cycle latency and no combinational RXFLIT-to-output path.

## Structure
- Shared package `hnf_chi_pkg` holds:
  - flit typedefs (`reqflit_t`, `rspflit_t`, `datflit_t`);
  - `CHI_MAX_LCRD = 15`;
  - per-channel `numCreditsForHN*` constants used to set DEPTH/MAX_LCRD at instantiation.
- Sub-module: the existing `sfifo` (WIDTH, DEPTH) is instantiated as the POS queue. Credit counter, pend register, bypass mux and error flags live in the top module.

## Test plan
- Reset release, DEPTH=8, MAX_LCRD=8, no traffic: RXLCRDV high for exactly 8 cycles, then low; `lcrd_outstanding`=8.
- DEPTH=4, MAX_LCRD=4, out_ready=0, send 4 flits (PEND one cycle ahead of each): occupancy=4, `lcrd_outstanding`=0, RXLCRDV stays 0. Pop 1 flit: exactly one RXLCRDV pulse follows.
- Steady stream, out_ready=1, MAX_LCRD=2, DEPTH=8: every flit consumes a credit and triggers one re-issue. `lcrd_outstanding` never exceeds 2, and data order is preserved across ≥3 pointer wraps.
- RXFLITV with `lcrd_outstanding`=0: `err_no_credit`=1, occupancy unchanged, flit absent from output.
- RXFLITV without preceding RXFLITPEND: flit delivered and `err_pend_miss`=1. Assert reset mid-stream with 3 queued: next cycle occupancy=0, out_valid=0, flags=0.
- With `HNF_RXCHAN_BYPASS_EN`, empty queue, out_ready=1: `out_flit`==RXFLIT in the same cycle and occupancy stays 0. Without the macro, out_valid rises one cycle later.

Source files
------------

// File: rtl/hnf_chi_pkg.sv
// Shared CHI link-layer types and per-channel credit sizing for the HN-F.
// Flit typedefs fix the WIDTH of each receive channel instance.
package hnf_chi_pkg;

  localparam int CHI_MAX_LCRD = 15;

  localparam int REQ_FLIT_W = 100;
  localparam int RSP_FLIT_W = 51;
  localparam int DAT_FLIT_W = 200;

  typedef logic [REQ_FLIT_W-1:0] reqflit_t;
  typedef logic [RSP_FLIT_W-1:0] rspflit_t;
  typedef logic [DAT_FLIT_W-1:0] datflit_t;

  localparam int numCreditsForHNReq = 8;
  localparam int numCreditsForHNRsp = 4;
  localparam int numCreditsForHNDat = 8;

  typedef enum logic [1:0] {
    CH_REQ = 2'd0,
    CH_RSP = 2'd1,
    CH_DAT = 2'd2
  } chi_chan_e;

  // Clamp a requested credit count to what the link layer can carry.
  function automatic int lcrd_cap(input int req);
    return (req > CHI_MAX_LCRD) ? CHI_MAX_LCRD : req;
  endfunction

endpackage

// File: rtl/sfifo.sv
// Synchronous FIFO used as the receive-channel POS queue.
// Pointers wrap at DEPTH, so DEPTH need not be a power of two.
module sfifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointer and fill-level tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop)  rd_ptr <= inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/hnf_rxchan_lcrd.sv
// HN-F CHI receive channel: L-credit counter, FLITPEND check, POS queue.
// Define HNF_RXCHAN_BYPASS_EN for a same-cycle empty-queue bypass path.
import hnf_chi_pkg::*;

module hnf_rxchan_lcrd #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 8,
  parameter int MAX_LCRD = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        RXFLITPEND,
  input  logic                        RXFLITV,
  input  logic [WIDTH-1:0]            RXFLIT,
  output logic                        RXLCRDV,
  output logic [WIDTH-1:0]            out_flit,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [3:0]                  lcrd_outstanding,
  output logic [$clog2(DEPTH+1)-1:0]  occupancy,
  output logic                        err_no_credit,
  output logic                        err_pend_miss
);

  localparam int LCRD_MAX = lcrd_cap(MAX_LCRD);

  logic             pend_q;
  logic [3:0]       lcrd_q;
  logic [3:0]       lcrd_eff;
  logic             rx;
  logic             has_cred;
  logic             consume;
  logic             q_push;
  logic             q_pop;
  logic             q_empty;
  logic             q_full;
  logic [WIDTH-1:0] q_dout;
  logic             issue;
  int               occ_eff;

  assign rx               = RXFLITV;
  assign has_cred         = (lcrd_q != 4'd0);
  assign consume          = rx & has_cred;
  assign lcrd_outstanding = lcrd_q;

  sfifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_q (
    .clock (clock),
    .reset (reset),
    .push  (q_push),
    .din   (RXFLIT),
    .pop   (q_pop),
    .dout  (q_dout),
    .empty (q_empty),
    .full  (q_full),
    .count (occupancy)
  );

`ifdef HNF_RXCHAN_BYPASS_EN
  // Empty queue: present the arriving flit directly, skip the write if taken.
  always_comb begin
    q_push    = consume & ~(q_empty & out_ready);
    q_pop     = ~q_empty & out_ready;
    out_valid = ~q_empty | consume;
    out_flit  = q_empty ? RXFLIT : q_dout;
  end
`else
  // Registered-only output path.
  always_comb begin
    q_push    = consume;
    q_pop     = ~q_empty & out_ready;
    out_valid = ~q_empty;
    out_flit  = q_dout;
  end
`endif

  // Credit issue: count this cycle's push and consume, not this cycle's pop.
  always_comb begin
    lcrd_eff = lcrd_q - 4'(consume);
    occ_eff  = int'(occupancy) + int'(q_push);
    issue    = (int'(lcrd_eff) < LCRD_MAX) &&
               (occ_eff + int'(lcrd_eff) < DEPTH);
  end

  // Credit counter, grant pulse and FLITPEND history.
  always_ff @(posedge clock) begin
    if (reset) begin
      lcrd_q  <= 4'd0;
      RXLCRDV <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      lcrd_q  <= lcrd_eff + 4'(issue);
      RXLCRDV <= issue;
      pend_q  <= RXFLITPEND;
    end
  end

  // Sticky protocol error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_no_credit <= 1'b0;
      err_pend_miss <= 1'b0;
    end else begin
      if (rx & ~has_cred) err_no_credit <= 1'b1;
      if (rx & ~pend_q)   err_pend_miss <= 1'b1;
    end
  end

  logic unused_full;
  assign unused_full = q_full;

endmodule

// File: tb/tb_hnf_rxchan_lcrd.sv
// Directed bench for hnf_rxchan_lcrd with three parameter sets.
// Checks reset, credit flow, fill/pop, stream order, errors and bypass.
module tb_hnf_rxchan_lcrd;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  // Instance A: DEPTH 8, MAX_LCRD 8
  logic        pend_a = 0, v_a = 0, rdy_a = 0;
  logic [63:0] flit_a = '0;
  logic        lcrdv_a, ovalid_a, enc_a, epm_a;
  logic [63:0] oflit_a;
  logic [3:0]  lcnt_a;
  logic [3:0]  occ_a;

  // Instance B: DEPTH 4, MAX_LCRD 4
  logic        pend_b = 0, v_b = 0, rdy_b = 0;
  logic [63:0] flit_b = '0;
  logic        lcrdv_b, ovalid_b, enc_b, epm_b;
  logic [63:0] oflit_b;
  logic [3:0]  lcnt_b;
  logic [2:0]  occ_b;

  // Instance C: DEPTH 8, MAX_LCRD 2
  logic        pend_c = 0, v_c = 0, rdy_c = 0;
  logic [63:0] flit_c = '0;
  logic        lcrdv_c, ovalid_c, enc_c, epm_c;
  logic [63:0] oflit_c;
  logic [3:0]  lcnt_c;
  logic [3:0]  occ_c;

  hnf_rxchan_lcrd #(.WIDTH(64), .DEPTH(8), .MAX_LCRD(8)) dut_a (
    .clock(clock), .reset(reset),
    .RXFLITPEND(pend_a), .RXFLITV(v_a), .RXFLIT(flit_a),
    .RXLCRDV(lcrdv_a), .out_flit(oflit_a), .out_valid(ovalid_a),
    .out_ready(rdy_a), .lcrd_outstanding(lcnt_a), .occupancy(occ_a),
    .err_no_credit(enc_a), .err_pend_miss(epm_a)
  );

  hnf_rxchan_lcrd #(.WIDTH(64), .DEPTH(4), .MAX_LCRD(4)) dut_b (
    .clock(clock), .reset(reset),
    .RXFLITPEND(pend_b), .RXFLITV(v_b), .RXFLIT(flit_b),
    .RXLCRDV(lcrdv_b), .out_flit(oflit_b), .out_valid(ovalid_b),
    .out_ready(rdy_b), .lcrd_outstanding(lcnt_b), .occupancy(occ_b),
    .err_no_credit(enc_b), .err_pend_miss(epm_b)
  );

  hnf_rxchan_lcrd #(.WIDTH(64), .DEPTH(8), .MAX_LCRD(2)) dut_c (
    .clock(clock), .reset(reset),
    .RXFLITPEND(pend_c), .RXFLITV(v_c), .RXFLIT(flit_c),
    .RXLCRDV(lcrdv_c), .out_flit(oflit_c), .out_valid(ovalid_c),
    .out_ready(rdy_c), .lcrd_outstanding(lcnt_c), .occupancy(occ_c),
    .err_no_credit(enc_c), .err_pend_miss(epm_c)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    int cnt;
    reset = 1'b1;
    step();
    step();
    n_chk++;
    if (lcrdv_a !== 1'b0 || ovalid_a !== 1'b0 || lcnt_a !== 4'd0 ||
        occ_a !== 4'd0 || enc_a !== 1'b0 || epm_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a: lcrdv=%b ov=%b lcrd=%0d occ=%0d e=%b%b want all 0",
               lcrdv_a, ovalid_a, lcnt_a, occ_a, enc_a, epm_a);
    end
    n_chk++;
    if (lcrdv_b !== 1'b0 || ovalid_b !== 1'b0 || lcnt_b !== 4'd0 ||
        occ_b !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_b: lcrdv=%b ov=%b lcrd=%0d occ=%0d want all 0",
               lcrdv_b, ovalid_b, lcnt_b, occ_b);
    end
    reset = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_chk++;
      if (lcrdv_a !== (k <= 8)) begin
        n_fail++;
        $display("FAIL credit_pulse cycle %0d: got %b want %b",
                 k, lcrdv_a, (k <= 8));
      end
      if (lcrdv_a === 1'b1) cnt++;
    end
    n_chk++;
    if (cnt != 8) begin
      n_fail++;
      $display("FAIL credit_count: got %0d want 8", cnt);
    end
    n_chk++;
    if (lcnt_a !== 4'd8) begin
      n_fail++;
      $display("FAIL lcrd_a_init: got %0d want 8", lcnt_a);
    end
    n_chk++;
    if (lcnt_b !== 4'd4 || lcnt_c !== 4'd2) begin
      n_fail++;
      $display("FAIL lcrd_bc_init: got %0d/%0d want 4/2", lcnt_b, lcnt_c);
    end
  endtask

  task automatic test_fill();
    logic [63:0] f [4];
    int cnt;
    for (int i = 0; i < 4; i++) f[i] = 64'hB000_0000_0000_0010 + 64'(i);
    rdy_b = 1'b0;
    pend_b = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      v_b = 1'b1;
      flit_b = f[i];
      pend_b = (i < 3);
      step();
    end
    v_b = 1'b0;
    pend_b = 1'b0;
    n_chk++;
    if (occ_b !== 3'd4 || lcnt_b !== 4'd0) begin
      n_fail++;
      $display("FAIL fill_level: occ=%0d lcrd=%0d want 4/0", occ_b, lcnt_b);
    end
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      if (lcrdv_b === 1'b1) cnt++;
      step();
    end
    n_chk++;
    if (cnt != 0) begin
      n_fail++;
      $display("FAIL fill_no_grant: got %0d pulses want 0", cnt);
    end
    n_chk++;
    if (ovalid_b !== 1'b1 || oflit_b !== f[0]) begin
      n_fail++;
      $display("FAIL fill_head: ov=%b flit=%h want 1/%h", ovalid_b, oflit_b, f[0]);
    end
    rdy_b = 1'b1;
    step();
    rdy_b = 1'b0;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (lcrdv_b === 1'b1) cnt++;
      step();
    end
    n_chk++;
    if (cnt != 1) begin
      n_fail++;
      $display("FAIL pop_regrant: got %0d pulses want 1", cnt);
    end
    n_chk++;
    if (occ_b !== 3'd3 || lcnt_b !== 4'd1 || oflit_b !== f[1]) begin
      n_fail++;
      $display("FAIL pop_state: occ=%0d lcrd=%0d flit=%h want 3/1/%h",
               occ_b, lcnt_b, oflit_b, f[1]);
    end
  endtask

  task automatic test_no_credit();
    logic [63:0] exp_q [4];
    int n;
    for (int i = 0; i < 4; i++) exp_q[i] = 64'hB000_0000_0000_0011 + 64'(i);
    pend_b = 1'b1;
    step();
    v_b = 1'b1;
    flit_b = exp_q[3];
    step();
    n_chk++;
    if (occ_b !== 3'd4 || lcnt_b !== 4'd0 || enc_b !== 1'b0) begin
      n_fail++;
      $display("FAIL last_credit: occ=%0d lcrd=%0d enc=%b want 4/0/0",
               occ_b, lcnt_b, enc_b);
    end
    flit_b = 64'hDEAD_BEEF_DEAD_BEEF;
    pend_b = 1'b0;
    step();
    v_b = 1'b0;
    n_chk++;
    if (enc_b !== 1'b1 || occ_b !== 3'd4 || epm_b !== 1'b0) begin
      n_fail++;
      $display("FAIL no_credit: enc=%b occ=%0d epm=%b want 1/4/0",
               enc_b, occ_b, epm_b);
    end
    rdy_b = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      if (ovalid_b === 1'b1) begin
        n_chk++;
        if (n >= 4 || oflit_b !== exp_q[n % 4]) begin
          n_fail++;
          $display("FAIL drain_b[%0d]: got %h want %h", n, oflit_b, exp_q[n % 4]);
        end
        n++;
      end
      step();
    end
    rdy_b = 1'b0;
    n_chk++;
    if (n != 4 || ovalid_b !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_b_count: got %0d ov=%b want 4/0", n, ovalid_b);
    end
  endtask

  task automatic test_stream();
    logic [63:0] s [30];
    int tx, sent, got, pulses;
    bit over;
    for (int i = 0; i < 30; i++) s[i] = 64'hA5A5_0000_0000_0000 | 64'(i * 7 + 1);
    n_chk++;
    if (lcnt_c !== 4'd2) begin
      n_fail++;
      $display("FAIL stream_start: lcrd=%0d want 2", lcnt_c);
    end
    tx = 2; sent = 0; got = 0; pulses = 0; over = 0;
    rdy_c = 1'b1;
    pend_c = 1'b1;
    step();
    for (int k = 0; k < 200 && got < 30; k++) begin
      if (lcrdv_c === 1'b1) begin
        pulses++;
        tx++;
      end
      if (sent < 30 && tx > 0) begin
        v_c = 1'b1;
        flit_c = s[sent];
        sent++;
        tx--;
      end else begin
        v_c = 1'b0;
      end
      #1;
      if (lcnt_c > 4'd2) over = 1;
      if (ovalid_c === 1'b1) begin
        n_chk++;
        if (got >= sent || oflit_c !== s[got]) begin
          n_fail++;
          $display("FAIL stream_data[%0d]: got %h want %h", got, oflit_c, s[got]);
        end
        got++;
      end
      step();
    end
    v_c = 1'b0;
    n_chk++;
    if (got != 30) begin
      n_fail++;
      $display("FAIL stream_timeout: delivered %0d want 30", got);
    end
    for (int k = 0; k < 4; k++) begin
      if (lcrdv_c === 1'b1) pulses++;
      step();
    end
    n_chk++;
    if (pulses != 30) begin
      n_fail++;
      $display("FAIL stream_regrant: got %0d pulses want 30", pulses);
    end
    n_chk++;
    if (over || lcnt_c !== 4'd2 || enc_c !== 1'b0 || epm_c !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_end: over=%b lcrd=%0d enc=%b epm=%b want 0/2/0/0",
               over, lcnt_c, enc_c, epm_c);
    end
    pend_c = 1'b0;
  endtask

  task automatic test_pend_miss_reset();
    logic [63:0] p0;
    p0 = 64'h0123_4567_89AB_CDEF;
    rdy_a = 1'b0;
    pend_a = 1'b0;
    v_a = 1'b1;
    flit_a = p0;
    step();
    v_a = 1'b0;
    n_chk++;
    if (epm_a !== 1'b1 || occ_a !== 4'd1 || ovalid_a !== 1'b1 || oflit_a !== p0) begin
      n_fail++;
      $display("FAIL pend_miss: epm=%b occ=%0d ov=%b flit=%h want 1/1/1/%h",
               epm_a, occ_a, ovalid_a, oflit_a, p0);
    end
    pend_a = 1'b1;
    step();
    v_a = 1'b1;
    flit_a = 64'h1111;
    step();
    flit_a = 64'h2222;
    step();
    v_a = 1'b0;
    pend_a = 1'b0;
    n_chk++;
    if (occ_a !== 4'd3 || lcnt_a !== 4'd5) begin
      n_fail++;
      $display("FAIL three_queued: occ=%0d lcrd=%0d want 3/5", occ_a, lcnt_a);
    end
    reset = 1'b1;
    step();
    n_chk++;
    if (occ_a !== 4'd0 || ovalid_a !== 1'b0 || epm_a !== 1'b0 || enc_a !== 1'b0 ||
        lcnt_a !== 4'd0 || lcrdv_a !== 1'b0 || enc_b !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: occ=%0d ov=%b epm=%b enc=%b lcrd=%0d lcrdv=%b want 0s",
               occ_a, ovalid_a, epm_a, enc_a, lcnt_a, lcrdv_a);
    end
    reset = 1'b0;
  endtask

  task automatic test_bypass();
    logic [63:0] b0;
    b0 = 64'hFEED_FACE_0BAD_F00D;
    for (int k = 0; k < 10; k++) step();
    rdy_a = 1'b1;
    pend_a = 1'b1;
    step();
    v_a = 1'b1;
    flit_a = b0;
    pend_a = 1'b0;
    #1;
`ifdef HNF_RXCHAN_BYPASS_EN
    n_chk++;
    if (ovalid_a !== 1'b1 || oflit_a !== b0) begin
      n_fail++;
      $display("FAIL bypass_same_cycle: ov=%b flit=%h want 1/%h", ovalid_a, oflit_a, b0);
    end
`else
    n_chk++;
    if (ovalid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL no_bypass_same_cycle: ov=%b want 0", ovalid_a);
    end
`endif
    step();
    v_a = 1'b0;
    #1;
`ifdef HNF_RXCHAN_BYPASS_EN
    n_chk++;
    if (occ_a !== 4'd0 || ovalid_a !== 1'b0 || lcnt_a !== 4'd8 || lcrdv_a !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_after: occ=%0d ov=%b lcrd=%0d lcrdv=%b want 0/0/8/1",
               occ_a, ovalid_a, lcnt_a, lcrdv_a);
    end
`else
    n_chk++;
    if (occ_a !== 4'd1 || ovalid_a !== 1'b1 || oflit_a !== b0 ||
        lcnt_a !== 4'd7 || lcrdv_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reg_after: occ=%0d ov=%b flit=%h lcrd=%0d lcrdv=%b want 1/1/%h/7/0",
               occ_a, ovalid_a, oflit_a, lcnt_a, lcrdv_a, b0);
    end
`endif
    step();
    n_chk++;
    if (occ_a !== 4'd0 || ovalid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_drained: occ=%0d ov=%b want 0/0", occ_a, ovalid_a);
    end
    rdy_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_no_credit();
    test_stream();
    test_pend_miss_reset();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
